axi_sram_slave: RTL
===================

// Module: axi_sram_slave
// PURPOSE
//  AXI3 single-beat slave (responder) that fronts a word-wide synchronous SRAM; the target end of the CPU AXI bridge.
//  Accepts AR, AW and W independently, serialises one transaction at a time, and drives the R or B response.
//  Used as the bench/SoC memory model behind the CPU bridge. Supports optional response-latency stretching.
// PARAMETERS
//  ADDR_W   10  SRAM word-address width; ram_addr = axaddr[ADDR_W+1:2]
//  DELAY     3  extra cycles before R/B response (only with AXI_SLV_DELAY_EN), 1..15
// PORTS
//  aclk      in   1   clock; single clock domain
//  areset    in   1   reset, synchronous, active-high
//  arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot  in  4/32/8/3/2/2/4/3  read address
//  arvalid in 1; arready out 1                          read address handshake
//  rid out 4; rdata out 32; rresp out 2; rlast out 1    read data
//  rvalid out 1; rready in 1                            read data handshake
//  awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot  in  4/32/8/3/2/2/4/3  write address
//  awvalid in 1; awready out 1                          write address handshake
//  wid in 4; wdata in 32; wstrb in 4; wlast in 1        write data
//  wvalid in 1; wready out 1                            write data handshake
//  bid out 4; bresp out 2; bvalid out 1; bready in 1    write response
//  ram_en out 1; ram_we out 4; ram_addr out ADDR_W; ram_wdata out 32; ram_rdata in 32  SRAM, 1-cycle read latency
// BEHAVIOUR
//  Reset: state=IDLE; aw_held=w_held=0; all valid/ready/ram_en/ram_we=0; rid,bid,rresp,bresp,rdata=0. A transaction
//   in flight when areset rises is dropped with no response; readies are forced 0 while areset=1.
//  Holding regs: AW fires (awvalid&awready) -> latch awid/awaddr/awlen, aw_held=1. W fires -> latch wdata/wstrb, w_held=1.
//  awready = IDLE & ~aw_held; wready = IDLE & ~w_held. AW and W may arrive in either order or the same cycle.
//  arready = IDLE & ~aw_held & ~w_held & ~awvalid & ~wvalid (writes take priority over reads).
//  FSM states and transitions:
//   IDLE     : aw_held&w_held -> WR_ISSUE; else AR fires -> latch arid/araddr/arlen -> RD_ISSUE.
//   RD_ISSUE : ram_en=1, ram_we=0, ram_addr from araddr -> RD_CAPT (skip RAM and go to RD_CAPT if arlen!=0).
//   RD_CAPT  : rdata<=ram_rdata (0 if arlen!=0) -> DLY (feature on) or R_RESP.
//   R_RESP   : rvalid=1, rid=latched arid, rlast=1, rresp=00 (10 SLVERR if arlen!=0); rvalid&rready -> IDLE.
//   WR_ISSUE : ram_en=1, ram_we=wstrb (0 if awlen!=0), ram_addr from awaddr, ram_wdata=wdata;
//              clear aw_held,w_held -> DLY or B_RESP.
//   B_RESP   : bvalid=1, bid=latched awid, bresp=00 (10 if awlen!=0); bvalid&bready -> IDLE.
//  Timing: a read with rready held 1 has rvalid in the 3rd cycle after the AR handshake. A write whose AW and W
//   handshakes coincide has bvalid in the 2nd cycle after them. Back-to-back transactions need one IDLE cycle between them.
//  rvalid/bvalid, once asserted, hold with stable payload until the handshake; rdata holds after the handshake until the next RD_CAPT.
//  arsize/awsize, burst, lock, cache, prot and wid/wlast are ignored. Byte lanes come from wstrb only. Reads always return the full word.
//  araddr/awaddr bits above ADDR_W+1 are ignored, so addresses wrap modulo 2^(ADDR_W+2) bytes.
//  Simultaneous AR and AW/W in IDLE: the write wins and AR stays pending (arready=0) until the write completes.
// CONFIGURATION
//  AXI_SLV_DELAY_EN defined: extra state DLY with 4-bit counter loaded with DELAY-1 on entry, decremented each cycle;
//   at 0 -> R_RESP or B_RESP per latched op. Adds DELAY cycles to both read and write latency.
//  Undefined: no DLY state or counter; RD_CAPT -> R_RESP and WR_ISSUE -> B_RESP directly.
// TESTING
//  Write awaddr=0x10, wdata=0xA5A5_1234, wstrb=0xF, AW and W same cycle, bready=1 -> ram_we=F @addr 4; bvalid next cycle, bid=awid, bresp=00.
//  W first (wdata=0xFFFF_FFFF, wstrb=0x2), AW 3 cycles later @0x10 -> word at 0x10 becomes 0xA5A5_FF34; awready stays 1 and wready 0 in between.
//  Read araddr=0x10 arid=1, rready low 5 cycles -> rvalid held, rdata=0xA5A5_FF34, rid=1, rlast=1 until rready.
//  awvalid and arvalid asserted same cycle in IDLE -> arready=0 until B handshake; AR then accepted and returns post-write data.
//  arlen=3 read -> single beat, rresp=10, rlast=1, ram_en never asserted.
//  areset pulsed during R_RESP -> rvalid=0 next cycle, state IDLE, no response produced; AXI_SLV_DELAY_EN build with DELAY=3 -> read latency 6 cycles.

Source files
------------

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: single-beat AXI3 responder in front of a word-wide synchronous SRAM.
// One transaction is serviced at a time. When both kinds are pending in IDLE, the write wins.
// Build option: define AXI_SLV_DELAY_EN to insert DELAY extra cycles before every R/B response.
module axi_sram_slave #(
  parameter int ADDR_W = 10,
  parameter int DELAY  = 3
) (
  input  logic              aclk,
  input  logic              areset,
  // read address
  input  logic [3:0]        arid,
  input  logic [31:0]       araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic [1:0]        arlock,
  input  logic [3:0]        arcache,
  input  logic [2:0]        arprot,
  input  logic              arvalid,
  output logic              arready,
  // read data
  output logic [3:0]        rid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  // write address
  input  logic [3:0]        awid,
  input  logic [31:0]       awaddr,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic [1:0]        awlock,
  input  logic [3:0]        awcache,
  input  logic [2:0]        awprot,
  input  logic              awvalid,
  output logic              awready,
  // write data
  input  logic [3:0]        wid,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  // write response
  output logic [3:0]        bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  // SRAM (1-cycle read latency)
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ISSUE = 3'd1,
    ST_RD_CAPT  = 3'd2,
    ST_R_RESP   = 3'd3,
    ST_WR_ISSUE = 3'd4,
    ST_B_RESP   = 3'd5
`ifdef AXI_SLV_DELAY_EN
    , ST_DLY    = 3'd6
`endif
  } state_e;

  state_e              state_r;
  state_e              state_s;

  // write-side holding registers
  logic                aw_held_r;
  logic                w_held_r;
  logic [ADDR_W-1:0]   awaddr_r;
  logic                awlen_nz_r;
  logic [3:0]          bid_r;
  logic [1:0]          bresp_r;
  logic [31:0]         wdata_r;
  logic [3:0]          wstrb_r;

  // read-side registers
  logic [ADDR_W-1:0]   araddr_r;
  logic                arlen_nz_r;
  logic [3:0]          rid_r;
  logic [1:0]          rresp_r;
  logic [31:0]         rdata_r;

  logic                idle_s;
  logic                awready_s;
  logic                wready_s;
  logic                arready_s;
  logic                aw_fire_s;
  logic                w_fire_s;
  logic                ar_fire_s;

`ifdef AXI_SLV_DELAY_EN
  logic [3:0]          dly_cnt_r;
  logic                rd_op_r;
`endif

  // Handshake qualifiers; readies are held low for the whole reset cycle.
  assign idle_s    = (state_r == ST_IDLE);
  assign awready_s = ~areset & idle_s & ~aw_held_r;
  assign wready_s  = ~areset & idle_s & ~w_held_r;
  assign arready_s = ~areset & idle_s & ~aw_held_r & ~w_held_r & ~awvalid & ~wvalid;
  assign aw_fire_s = awvalid & awready_s;
  assign w_fire_s  = wvalid & wready_s;
  assign ar_fire_s = arvalid & arready_s;

  assign awready   = awready_s;
  assign wready    = wready_s;
  assign arready   = arready_s;

  // State register; any transaction in flight is dropped on reset.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; a handshake in the current cycle counts as already held so
  // coincident AW/W go straight to WR_ISSUE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if ((aw_held_r | aw_fire_s) & (w_held_r | w_fire_s)) begin
          state_s = ST_WR_ISSUE;
        end else if (ar_fire_s) begin
          state_s = ST_RD_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RD_ISSUE: state_s = ST_RD_CAPT;
`ifdef AXI_SLV_DELAY_EN
      ST_RD_CAPT:  state_s = ST_DLY;
      ST_WR_ISSUE: state_s = ST_DLY;
      ST_DLY: begin
        if (dly_cnt_r == 4'd0) begin
          if (rd_op_r) begin
            state_s = ST_R_RESP;
          end else begin
            state_s = ST_B_RESP;
          end
        end else begin
          state_s = ST_DLY;
        end
      end
`else
      ST_RD_CAPT:  state_s = ST_R_RESP;
      ST_WR_ISSUE: state_s = ST_B_RESP;
`endif
      ST_R_RESP: begin
        if (rready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_R_RESP;
        end
      end
      ST_B_RESP: begin
        if (bready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_B_RESP;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // AW/W holding registers: latch on handshake, release once the SRAM write is issued.
  always_ff @(posedge aclk) begin
    if (areset) begin
      aw_held_r  <= 1'b0;
      w_held_r   <= 1'b0;
      awaddr_r   <= '0;
      awlen_nz_r <= 1'b0;
      bid_r      <= 4'h0;
      bresp_r    <= 2'b00;
      wdata_r    <= 32'h0;
      wstrb_r    <= 4'h0;
    end else begin
      if (aw_fire_s) begin
        aw_held_r  <= 1'b1;
        awaddr_r   <= awaddr[ADDR_W+1:2];
        awlen_nz_r <= (awlen != 8'd0);
        bid_r      <= awid;
        bresp_r    <= (awlen != 8'd0) ? 2'b10 : 2'b00;
      end else if (state_r == ST_WR_ISSUE) begin
        aw_held_r  <= 1'b0;
      end
      if (w_fire_s) begin
        w_held_r   <= 1'b1;
        wdata_r    <= wdata;
        wstrb_r    <= wstrb;
      end else if (state_r == ST_WR_ISSUE) begin
        w_held_r   <= 1'b0;
      end
    end
  end

  // Read request capture and read-data register; rdata holds until the next capture.
  always_ff @(posedge aclk) begin
    if (areset) begin
      araddr_r   <= '0;
      arlen_nz_r <= 1'b0;
      rid_r      <= 4'h0;
      rresp_r    <= 2'b00;
      rdata_r    <= 32'h0;
    end else begin
      if (ar_fire_s) begin
        araddr_r   <= araddr[ADDR_W+1:2];
        arlen_nz_r <= (arlen != 8'd0);
        rid_r      <= arid;
        rresp_r    <= (arlen != 8'd0) ? 2'b10 : 2'b00;
      end
      if (state_r == ST_RD_CAPT) begin
        rdata_r <= arlen_nz_r ? 32'h0 : ram_rdata;
      end
    end
  end

`ifdef AXI_SLV_DELAY_EN
  // Response delay counter and the operation kind it resumes into.
  always_ff @(posedge aclk) begin
    if (areset) begin
      dly_cnt_r <= 4'd0;
      rd_op_r   <= 1'b0;
    end else begin
      if ((state_r != ST_DLY) && (state_s == ST_DLY)) begin
        dly_cnt_r <= 4'(DELAY - 1);
      end else if ((state_r == ST_DLY) && (dly_cnt_r != 4'd0)) begin
        dly_cnt_r <= dly_cnt_r - 4'd1;
      end
      if (state_r == ST_RD_CAPT) begin
        rd_op_r <= 1'b1;
      end else if (state_r == ST_WR_ISSUE) begin
        rd_op_r <= 1'b0;
      end
    end
  end
`endif

  // Response channels decoded from the state register; payloads come from latched regs.
  assign rvalid    = (state_r == ST_R_RESP);
  assign rlast     = (state_r == ST_R_RESP);
  assign rid       = rid_r;
  assign rresp     = rresp_r;
  assign rdata     = rdata_r;
  assign bvalid    = (state_r == ST_B_RESP);
  assign bid       = bid_r;
  assign bresp     = bresp_r;

  // SRAM port: bursts never touch the array on reads and never write on writes.
  assign ram_en    = ((state_r == ST_RD_ISSUE) & ~arlen_nz_r) | (state_r == ST_WR_ISSUE);
  assign ram_we    = ((state_r == ST_WR_ISSUE) & ~awlen_nz_r) ? wstrb_r : 4'h0;
  assign ram_addr  = (state_r == ST_WR_ISSUE) ? awaddr_r : araddr_r;
  assign ram_wdata = wdata_r;

  // Attributes this responder deliberately ignores.
  logic unused_s;
`ifdef AXI_SLV_DELAY_EN
  assign unused_s = ^{arsize, arburst, arlock, arcache, arprot, araddr[31:ADDR_W+2], araddr[1:0],
                      awsize, awburst, awlock, awcache, awprot, awaddr[31:ADDR_W+2], awaddr[1:0],
                      wid, wlast};
`else
  assign unused_s = ^{arsize, arburst, arlock, arcache, arprot, araddr[31:ADDR_W+2], araddr[1:0],
                      awsize, awburst, awlock, awcache, awprot, awaddr[31:ADDR_W+2], awaddr[1:0],
                      wid, wlast, 4'(DELAY)};
`endif

endmodule
